// File: rtl/pc_sequencer_if.sv
// Bus between the multicycle control/datapath and the program-counter stage.
// master: control unit / datapath side; slave: pc_sequencer.
interface pc_sequencer_if;
  logic [31:0] pc_next;
  logic [2:0]  src_req;
  logic        pc_write;
  logic        branch_req;
  logic [1:0]  branch_type;
  logic        alu_zero;
  logic        alu_neg;
  logic        exc_req;
  logic        exc_cause;
  logic [2:0]  pc_source;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        vec_rd;
  logic [31:0] vec_addr;
  logic        exc_busy;
  logic        pc_updated;

  modport master (
    output pc_next, src_req, pc_write, branch_req, branch_type,
           alu_zero, alu_neg, exc_req, exc_cause,
    input  pc_source, pc, epc, vec_rd, vec_addr, exc_busy, pc_updated
  );

  modport slave (
    input  pc_next, src_req, pc_write, branch_req, branch_type,
           alu_zero, alu_neg, exc_req, exc_cause,
    output pc_source, pc, epc, vec_rd, vec_addr, exc_busy, pc_updated
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage of the multicycle MIPS datapath: PC/EPC registers,
// PC-source mux select, conditional PC write and the exception vector fetch.
module pc_sequencer #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXC_RD   = 2'd1,
    EXC_LOAD = 2'd2
  } state_t;

  localparam logic [3:0]  LAST_RD     = 4'(MEM_LAT - 1);
  localparam logic [31:0] VEC_OPCODE  = 32'h0000_00FE;
  localparam logic [31:0] VEC_OVFL    = 32'h0000_00FF;
  localparam logic [2:0]  SRC_PC4     = 3'd0;
  localparam logic [2:0]  SRC_VECTOR  = 3'd4;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        cause_q, cause_nx;
  logic [31:0] pc_q, pc_nx;
  logic [31:0] epc_q, epc_nx;
  logic        upd_q, upd_nx;
  logic        cond_ok;
  logic        take;
  logic        src_valid;

  // Branch condition evaluation from the ALU flags.
  always_comb begin
    cond_ok = 1'b0;
    case (bus.branch_type)
      2'd0:    cond_ok = bus.alu_zero;
      2'd1:    cond_ok = ~bus.alu_zero;
      2'd2:    cond_ok = bus.alu_neg | bus.alu_zero;
      default: cond_ok = ~bus.alu_neg & ~bus.alu_zero;
    endcase
  end

  assign take      = bus.pc_write | (bus.branch_req & cond_ok);
  assign src_valid = (bus.src_req <= SRC_VECTOR);

  // State, wait counter, latched cause and PC/EPC registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cause_q <= 1'b0;
      pc_q    <= '0;
      epc_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cause_q <= cause_nx;
      pc_q    <= pc_nx;
      epc_q   <= epc_nx;
      upd_q   <= upd_nx;
    end
  end

  // Next-state and output decode; exception entry outranks a PC write in IDLE.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    cause_nx      = cause_q;
    pc_nx         = pc_q;
    epc_nx        = epc_q;
    upd_nx        = 1'b0;
    bus.pc_source = SRC_PC4;
    bus.vec_rd    = 1'b0;
    bus.vec_addr  = '0;

    case (state)
      IDLE: begin
        bus.pc_source = bus.src_req;
        if (bus.exc_req) begin
          epc_nx   = pc_q - 32'd4;
          cause_nx = bus.exc_cause;
          cnt_nx   = '0;
          state_nx = EXC_RD;
        end else if (take && src_valid) begin
          pc_nx  = bus.pc_next;
          upd_nx = 1'b1;
        end
      end

      EXC_RD: begin
        bus.pc_source = SRC_PC4;
        bus.vec_rd    = 1'b1;
        bus.vec_addr  = cause_q ? VEC_OVFL : VEC_OPCODE;
        cnt_nx        = cnt + 4'd1;
        if (cnt == LAST_RD) begin
          state_nx = EXC_LOAD;
        end
      end

      EXC_LOAD: begin
        bus.pc_source = SRC_VECTOR;
        pc_nx         = bus.pc_next;
        upd_nx        = 1'b1;
        state_nx      = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.pc         = pc_q;
  assign bus.epc        = epc_q;
  assign bus.pc_updated = upd_q;
  assign bus.exc_busy   = (state != IDLE);

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage of the multicycle MIPS datapath. It holds the PC and EPC registers and consumes the 32-bit output of the PC-source mux. It drives that mux's 3-bit select and decides each cycle whether the PC is written. It also runs the exception sequence: it captures EPC, fetches the handler-vector byte from memory and loads it into the PC, stalling the main control unit meanwhile.

## Interface
- MEM_LAT, 2, memory read latency in cycles for the vector fetch; legal range 1..15.

Clock and reset: one clock; reset is synchronous and active-low.

- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- pc_next  in  32  output of the PC-source mux.
- src_req  in  3  requested mux select from the control unit:
  - 0 = PC+4
  - 1 = ALUOut branch target
  - 2 = jump target
  - 3 = register A (jr)
  - 4 = memory byte (vector)
  - 5..7 = invalid
- pc_write  in  1  unconditional PC write request.
- branch_req  in  1  conditional PC write request.
- branch_type  in  2  condition:
  - 0 = beq, taken if alu_zero
  - 1 = bne, taken if ~alu_zero
  - 2 = ble, taken if alu_neg | alu_zero
  - 3 = bgt, taken if ~alu_neg & ~alu_zero
- alu_zero  in  1  ALU zero flag.
- alu_neg  in  1  ALU result sign flag.
- exc_req  in  1  exception request, sampled in IDLE only.
- exc_cause  in  1  0 = invalid opcode, 1 = overflow.
- pc_source  out  3  select to the PC-source mux.
- pc  out  32  program counter.
- epc  out  32  exception PC.
- vec_rd  out  1  memory read strobe for the vector fetch.
- vec_addr  out  32  vector address: 0x000000FE for opcode, 0x000000FF for overflow.
- exc_busy  out  1  high while the exception sequence runs; the control unit freezes.
- pc_updated  out  1  registered one-cycle pulse, high the cycle after any PC write.

## Operation
- **States:** IDLE, EXC_RD, EXC_LOAD. The state and a 4-bit wait counter are registered.
- **IDLE:**
  - pc_source = src_req (combinational).
  - take = pc_write | (branch_req & cond(branch_type)).
  - If take and src_req ≤ 4: pc <= pc_next.
  - If src_req ≥ 5: pc holds, and pc_updated stays low.
- **exc_req in IDLE:**
  - Has priority over take in the same cycle; the PC is not written.
  - epc <= pc - 4, modulo 2^32 (pc = 0 gives 0xFFFFFFFC).
  - exc_cause is latched, the counter is cleared, and the state goes to EXC_RD.
- **EXC_RD:**
  - vec_rd = 1; vec_addr is derived from the latched cause; pc_source = 0.
  - The counter increments each cycle. After MEM_LAT cycles in EXC_RD, the state goes to EXC_LOAD.
- **EXC_LOAD:**
  - pc_source = 4; pc <= pc_next (the zero-extended vector byte supplied by the mux); vec_rd = 0.
  - The state returns to IDLE.
- **Busy-period inputs:** exc_busy = (state != IDLE). While busy, pc_write, branch_req and exc_req are ignored; there is no nesting and no queuing.
- **Static outputs:** vec_addr = 0 outside EXC_RD. epc changes only on exception entry.

## Timing
- **Reset values:** pc = 0, epc = 0, state IDLE, counter 0, pc_updated = 0. The combinational outputs follow: pc_source = src_req, vec_rd = 0, vec_addr = 0, exc_busy = 0.
- **Reset priority:** reset_n low at an edge overrides everything, including mid-exception. The sequence is abandoned and epc returns to 0.
- **Normal writes:** zero-cycle decision. pc_next is sampled at the edge that ends the requesting cycle. The new pc is visible in the next cycle, together with pc_updated = 1.
- **Exception latency:** exc_req sampled at edge E0.
  - Cycles E0..E0+MEM_LAT are EXC_RD.
  - The cycle after that is EXC_LOAD.
  - The new pc is visible after edge E0+MEM_LAT+1.
  - exc_busy is high for exactly MEM_LAT+1 cycles.
- **Combinational paths:** pc_source depends combinationally on src_req only in IDLE. There is no combinational path from pc_next to any output.

## Test plan
- **Reset:** reset_n = 0 for 2 cycles with pc_write = 1 and src_req = 0 -> pc = 0, epc = 0, exc_busy = 0, pc_updated = 0.
- **Sequential writes:** pc_write with src_req = 0 and pc_next = pc+4 for 3 cycles -> pc goes 4, 8, 12; pc_updated is high each following cycle.
- **Branch conditions:** branch_req with pc_next = 0x40 for every branch_type × {zero, neg} combination -> pc = 0x40 only when the condition holds, else pc holds. pc_write with src_req = 6 -> pc holds.
- **Overflow exception:** pc = 0x100, exc_req = 1, exc_cause = 1, MEM_LAT = 2, pc_next = 0x3C during EXC_LOAD:
  - epc = 0xFC.
  - vec_rd is high for 2 cycles with vec_addr = 0xFF.
  - pc_source = 4 for 1 cycle.
  - pc = 0x3C.
  - exc_busy is high for 3 cycles.
- **Collisions:** exc_req together with pc_write at pc = 0 -> pc is not written and epc = 0xFFFFFFFC. A second exc_req and a pc_write while busy -> both ignored.
- **Reset mid-exception:** reset_n low during EXC_RD -> next cycle IDLE, pc = 0, epc = 0, vec_rd = 0.
